cic_decimator_param: RTL and testbench

// - Parametrised N-stage CIC decimator, rate R = 2**DEC_LOG2, single clock domain.
// - Replaces a divided sample clock with an in_valid/out_valid strobe pair.
// - Sits between a PDM/low-width sample source and the tile output mux.
// - Output is the top OUT_WIDTH bits of the full-precision comb result.

---
 rtl/cic_decimator_param.sv | 106 ++++++++++
 tb/tb_cic_decimator_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator_param.sv
// N-stage CIC decimator, rate 2**DEC_LOG2, strobe-qualified input and output.
// Optional output rounding (round half up, saturating) when CIC_OUT_ROUND_EN is defined.
module cic_decimator_param #(
  parameter int STAGES    = 3,
  parameter int DEC_LOG2  = 3,
  parameter int IN_WIDTH  = 1,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int REG_WIDTH = IN_WIDTH + STAGES * DEC_LOG2;

  logic [REG_WIDTH-1:0] int_q      [STAGES];
  logic [REG_WIDTH-1:0] int_d      [STAGES];
  logic [REG_WIDTH-1:0] int_sum    [STAGES];
  logic [REG_WIDTH-1:0] comb_dly_q [STAGES];
  logic [REG_WIDTH-1:0] comb_dly_d [STAGES];
  logic [REG_WIDTH-1:0] comb_in    [STAGES];
  logic [REG_WIDTH-1:0] comb_out   [STAGES];
  logic [REG_WIDTH-1:0] comb_last;
  logic [REG_WIDTH-1:0] in_ext;
  logic [DEC_LOG2-1:0]  ctr_q, ctr_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [OUT_WIDTH-1:0] scaled;
  logic                 out_valid_q, out_valid_d;
  logic                 dec;

  assign in_ext = REG_WIDTH'(in_data);
  assign dec    = in_valid && (ctr_q == {DEC_LOG2{1'b1}});

  // Integrator and comb chains are purely combinational; only the registers below hold state.
  always_comb begin
    int_sum[0] = in_ext + int_q[0];
    for (int k = 1; k < STAGES; k++) begin
      int_sum[k] = int_sum[k-1] + int_q[k];
    end
    comb_in[0]  = int_sum[STAGES-1];
    comb_out[0] = comb_in[0] - comb_dly_q[0];
    for (int k = 1; k < STAGES; k++) begin
      comb_in[k]  = comb_out[k-1];
      comb_out[k] = comb_in[k] - comb_dly_q[k];
    end
  end

  assign comb_last = comb_out[STAGES-1];

`ifdef CIC_OUT_ROUND_EN
  if (OUT_WIDTH < REG_WIDTH) begin : g_round
    localparam logic [REG_WIDTH:0] HALF = (REG_WIDTH+1)'(1) << (REG_WIDTH - OUT_WIDTH - 1);
    logic [REG_WIDTH:0] rnd;
    assign rnd    = {1'b0, comb_last} + HALF;
    assign scaled = rnd[REG_WIDTH] ? {OUT_WIDTH{1'b1}} : rnd[REG_WIDTH-1 -: OUT_WIDTH];
  end else begin : g_pass
    assign scaled = comb_last[REG_WIDTH-1 -: OUT_WIDTH];
  end
`else
  assign scaled = comb_last[REG_WIDTH-1 -: OUT_WIDTH];
`endif

  always_comb begin
    int_d       = int_q;
    comb_dly_d  = comb_dly_q;
    ctr_d       = ctr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      int_d = int_sum;
      ctr_d = ctr_q + 1'b1;
    end
    if (dec) begin
      comb_dly_d  = comb_in;
      out_data_d  = scaled;
      out_valid_d = 1'b1;
    end
  end

  // clear behaves exactly like reset and overrides any sample presented with it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int k = 0; k < STAGES; k++) begin
        int_q[k]      <= '0;
        comb_dly_q[k] <= '0;
      end
      ctr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      int_q       <= int_d;
      comb_dly_q  <= comb_dly_d;
      ctr_q       <= ctr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cic_decimator_param.sv
// Directed bench for cic_decimator_param: default 3-stage R=8 instance plus a
// 1-stage 2-bit-output instance for the truncation/rounding case.
module tb_cic_decimator_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [0:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_valid2;
  logic [1:0] out_data2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] q_dat[$];
  int         q_cyc[$];
  logic [1:0] q2[$];

  always #5 clk = ~clk;

  cic_decimator_param #(.STAGES(3), .DEC_LOG2(3), .IN_WIDTH(1), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  cic_decimator_param #(.STAGES(1), .DEC_LOG2(3), .IN_WIDTH(1), .OUT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid2), .out_data(out_data2)
  );

  task automatic clr_q();
    q_dat.delete();
    q_cyc.delete();
    q2.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_q();
  endtask

  // mode 0: zeros, 1: ones, 2: alternating 1/0, 3: six ones per 8 samples
  task automatic drive(input int n, input int mode, input int period);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = ((i % period) == 0);
      case (mode)
        0:       in_data = 1'b0;
        1:       in_data = 1'b1;
        2:       in_data = ((acc % 2) == 0);
        default: in_data = ((acc % 8) < 6);
      endcase
      @(posedge clk);
      #1;
      cyc++;
      if (in_valid) acc++;
      if (out_valid) begin
        q_dat.push_back(out_data);
        q_cyc.push_back(cyc);
      end
      if (out_valid2) q2.push_back(out_data2);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_vld: got %0h expected 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_dat: got %0h expected 0", out_data); end
    tests++; if (out_data2 !== 2'h0) begin fails++; $display("FAIL reset_dat2: got %0h expected 0", out_data2); end
  endtask

  task automatic test_zero();
    do_reset();
    drive(40, 0, 1);
    tests++; if (q_dat.size() !== 5) begin fails++; $display("FAIL zero_count: got %0d expected 5", q_dat.size()); end
    tests++; if (q_cyc[1] - q_cyc[0] !== 8) begin fails++; $display("FAIL zero_spacing: got %0d expected 8", q_cyc[1] - q_cyc[0]); end
    for (int i = 0; i < q_dat.size(); i++) begin
      tests++; if (q_dat[i] !== 8'h00) begin fails++; $display("FAIL zero_dat%0d: got %0h expected 0", i, q_dat[i]); end
    end
  endtask

  task automatic test_ones();
    do_reset();
    drive(48, 1, 1);
    tests++; if (q_dat.size() !== 6) begin fails++; $display("FAIL ones_count: got %0d expected 6", q_dat.size()); end
    tests++; if (q_dat[0] !== 8'h1E) begin fails++; $display("FAIL ones_t1: got %0h expected 1e", q_dat[0]); end
    tests++; if (q_dat[1] !== 8'h72) begin fails++; $display("FAIL ones_t2: got %0h expected 72", q_dat[1]); end
    tests++; if (q_dat[3] !== 8'h80) begin fails++; $display("FAIL ones_s4: got %0h expected 80", q_dat[3]); end
    tests++; if (q_dat[5] !== 8'h80) begin fails++; $display("FAIL ones_s6: got %0h expected 80", q_dat[5]); end
  endtask

  task automatic test_alternating();
    do_reset();
    drive(48, 2, 1);
    tests++; if (q_dat[3] !== 8'h40) begin fails++; $display("FAIL alt_s4: got %0h expected 40", q_dat[3]); end
    tests++; if (q_dat[5] !== 8'h40) begin fails++; $display("FAIL alt_s6: got %0h expected 40", q_dat[5]); end
  endtask

  task automatic test_gaps();
    do_reset();
    drive(128, 1, 2);
    tests++; if (q_dat.size() !== 8) begin fails++; $display("FAIL gap_count: got %0d expected 8", q_dat.size()); end
    tests++; if (q_cyc[4] - q_cyc[3] !== 16) begin fails++; $display("FAIL gap_spacing: got %0d expected 16", q_cyc[4] - q_cyc[3]); end
    tests++; if (q_dat[0] !== 8'h1E) begin fails++; $display("FAIL gap_t1: got %0h expected 1e", q_dat[0]); end
    tests++; if (q_dat[4] !== 8'h80) begin fails++; $display("FAIL gap_s5: got %0h expected 80", q_dat[4]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(16, 1, 1);
    drive(5, 1, 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_vld: got %0h expected 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rstmid_dat: got %0h expected 0", out_data); end
    rst_n = 1'b1;
    clr_q();
    drive(7, 1, 1);
    tests++; if (q_dat.size() !== 0) begin fails++; $display("FAIL rstmid_early: got %0d strobes expected 0", q_dat.size()); end
    drive(1, 1, 1);
    tests++; if (q_dat.size() !== 1) begin fails++; $display("FAIL rstmid_strobe: got %0d strobes expected 1", q_dat.size()); end
    tests++; if (q_dat[0] !== 8'h1E) begin fails++; $display("FAIL rstmid_val: got %0h expected 1e", q_dat[0]); end
  endtask

  task automatic test_clear();
    do_reset();
    drive(16, 1, 1);
    drive(7, 1, 1);
    clr_q();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    clear = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_vld: got %0h expected 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL clear_dat: got %0h expected 0", out_data); end
    drive(7, 1, 1);
    tests++; if (q_dat.size() !== 0) begin fails++; $display("FAIL clear_early: got %0d strobes expected 0", q_dat.size()); end
    drive(1, 1, 1);
    tests++; if (q_dat.size() !== 1) begin fails++; $display("FAIL clear_strobe: got %0d strobes expected 1", q_dat.size()); end
    tests++; if (q_dat[0] !== 8'h1E) begin fails++; $display("FAIL clear_val: got %0h expected 1e", q_dat[0]); end
  endtask

  task automatic test_small_scale();
    logic [1:0] exp_v;
`ifdef CIC_OUT_ROUND_EN
    exp_v = 2'd2;
`else
    exp_v = 2'd1;
`endif
    do_reset();
    drive(32, 3, 1);
    tests++; if (q2.size() !== 4) begin fails++; $display("FAIL small_count: got %0d expected 4", q2.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (q2[i] !== exp_v) begin fails++; $display("FAIL small_s%0d: got %0d expected %0d", i, q2[i], exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ones();
    test_alternating();
    test_gaps();
    test_reset_mid();
    test_clear();
    test_small_scale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
